// File: rtl/fetch_unit.sv
// Fetch unit: architectural PC plus instruction-fetch sequencer.
// Issues word reads to imem and presents one instruction to decode.
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        exc_adel
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_exc;

    state_t      w_state_n;
    logic [31:0] w_pc_n;
    logic [31:0] w_req_addr_n;
    logic        w_valid_n;
    logic [31:0] w_instr_n;
    logic [31:0] w_instr_pc_n;
    logic        w_exc_n;
    logic        w_accept;
    logic        w_can_issue;
    logic        w_misaligned;

    assign w_accept     = r_valid & ~stall;
    assign w_can_issue  = ~r_valid | w_accept;
    assign w_misaligned = (r_pc[1:0] != 2'b00);

    assign valid    = r_valid;
    assign instr    = r_instr;
    assign instr_pc = r_instr_pc;
    assign exc_adel = r_exc;

    // Next-state, slot update and memory request generation
    always_comb begin
        w_state_n    = r_state;
        w_pc_n       = r_pc;
        w_req_addr_n = r_req_addr;
        w_valid_n    = r_valid & ~w_accept;
        w_instr_n    = r_instr;
        w_instr_pc_n = r_instr_pc;
        w_exc_n      = r_exc;
        imem_req     = 1'b0;
        imem_addr    = r_req_addr;
        unique case (r_state)
            IDLE: begin
                imem_addr = r_pc;
                imem_req  = w_can_issue & ~redirect & ~w_misaligned;
                if (redirect) begin
                    w_pc_n    = redirect_pc;
                    w_valid_n = 1'b0;
                end else if (w_can_issue && w_misaligned) begin
                    // Address error: deliver a marked empty slot, hold pc
                    w_valid_n    = 1'b1;
                    w_instr_n    = 32'h0;
                    w_instr_pc_n = r_pc;
                    w_exc_n      = 1'b1;
                end else if (w_can_issue) begin
                    w_req_addr_n = r_pc;
                    if (imem_ack) begin
                        w_valid_n    = 1'b1;
                        w_instr_n    = imem_rdata;
                        w_instr_pc_n = r_pc;
                        w_exc_n      = 1'b0;
                        w_pc_n       = r_pc + 32'd4;
                    end else begin
                        w_state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                imem_req = 1'b1;
                if (imem_ack && !redirect) begin
                    w_valid_n    = 1'b1;
                    w_instr_n    = imem_rdata;
                    w_instr_pc_n = r_req_addr;
                    w_exc_n      = 1'b0;
                    w_pc_n       = r_pc + 32'd4;
                    w_state_n    = IDLE;
                end else if (imem_ack) begin
                    w_pc_n    = redirect_pc;
                    w_state_n = IDLE;
                end else if (redirect) begin
                    w_pc_n    = redirect_pc;
                    w_state_n = DROP;
                end
            end
            DROP: begin
                // Outstanding request must complete; its data is stale
                imem_req = 1'b1;
                if (redirect) begin
                    w_pc_n = redirect_pc;
                end
                if (imem_ack) begin
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    // State, PC and output slot registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pc       <= PC_RESET;
            r_req_addr <= PC_RESET;
            r_valid    <= 1'b0;
            r_instr    <= 32'h0;
            r_instr_pc <= PC_RESET;
            r_exc      <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_pc       <= w_pc_n;
            r_req_addr <= w_req_addr_n;
            r_valid    <= w_valid_n;
            r_instr    <= w_instr_n;
            r_instr_pc <= w_instr_pc_n;
            r_exc      <= w_exc_n;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a latency-programmable
// instruction memory model (rdata = addr ^ 32'hFFFF0000).
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        exc_adel;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 0;
    int cnt      = 0;

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .valid      (valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .exc_adel   (exc_adel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: ack after 'lat' cycles of a held request
    always_comb begin
        imem_ack   = imem_req && (cnt >= lat);
        imem_rdata = imem_addr ^ 32'hFFFF0000;
    end

    always @(posedge clk) begin
        if (reset || !imem_req || imem_ack) cnt <= 0;
        else cnt <= cnt + 1;
    end

    task automatic do_reset();
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        stall = 1'b0;
        lat = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        stall = 1'b0;
        lat = 0;
        @(negedge clk);
        #1;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid); end
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", instr); end
        n_checks++; if (instr_pc !== 32'h3000) begin n_fail++; $display("FAIL rst_instr_pc: got %h want 3000", instr_pc); end
        n_checks++; if (exc_adel !== 1'b0) begin n_fail++; $display("FAIL rst_exc: got %b want 0", exc_adel); end
        n_checks++; if (imem_addr !== 32'h3000) begin n_fail++; $display("FAIL rst_addr: got %h want 3000", imem_addr); end
    endtask

    // Zero-wait back-to-back fetch followed by a 3-cycle stall
    task automatic test_back_to_back_stall();
        do_reset();
        #1;
        n_checks++; if (imem_addr !== 32'h3000 || imem_req !== 1'b1) begin n_fail++; $display("FAIL bb_addr0: got %h/%b want 3000/1", imem_addr, imem_req); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL bb_valid0: got %b want 0", valid); end
        @(negedge clk); #1;
        n_checks++; if (imem_addr !== 32'h3004) begin n_fail++; $display("FAIL bb_addr1: got %h want 3004", imem_addr); end
        n_checks++; if (valid !== 1'b1 || instr_pc !== 32'h3000) begin n_fail++; $display("FAIL bb_slot1: got %b/%h want 1/3000", valid, instr_pc); end
        n_checks++; if (instr !== 32'hFFFF3000) begin n_fail++; $display("FAIL bb_instr1: got %h want FFFF3000", instr); end
        @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL st_req%0d: got %b want 0", i, imem_req); end
            n_checks++; if (valid !== 1'b1 || instr_pc !== 32'h3004 || instr !== 32'hFFFF3004) begin n_fail++; $display("FAIL st_slot%0d: got %b/%h/%h want 1/3004/FFFF3004", i, valid, instr_pc, instr); end
            @(negedge clk);
        end
        stall = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008) begin n_fail++; $display("FAIL st_resume: got %b/%h want 1/3008", imem_req, imem_addr); end
        @(negedge clk); #1;
        n_checks++; if (valid !== 1'b1 || instr_pc !== 32'h3008 || imem_addr !== 32'h300C) begin n_fail++; $display("FAIL st_after: got %b/%h/%h want 1/3008/300C", valid, instr_pc, imem_addr); end
    endtask

    // Redirect while waiting on a slow fetch of 3008
    task automatic test_redirect_wait();
        do_reset();
        @(negedge clk);
        @(negedge clk);
        lat = 2;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008 || imem_ack !== 1'b0) begin n_fail++; $display("FAIL rw_issue: got %b/%h/%b want 1/3008/0", imem_req, imem_addr, imem_ack); end
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h4000;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008 || valid !== 1'b0) begin n_fail++; $display("FAIL rw_wait: got %b/%h/%b want 1/3008/0", imem_req, imem_addr, valid); end
        @(negedge clk);
        redirect = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008 || imem_ack !== 1'b1) begin n_fail++; $display("FAIL rw_drop: got %b/%h/%b want 1/3008/1", imem_req, imem_addr, imem_ack); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rw_drop_valid: got %b want 0", valid); end
        @(negedge clk);
        lat = 0;
        #1;
        n_checks++; if (valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4000) begin n_fail++; $display("FAIL rw_next: got %b/%b/%h want 0/1/4000", valid, imem_req, imem_addr); end
        @(negedge clk); #1;
        n_checks++; if (valid !== 1'b1 || instr_pc !== 32'h4000 || instr !== 32'hFFFF4000) begin n_fail++; $display("FAIL rw_slot: got %b/%h/%h want 1/4000/FFFF4000", valid, instr_pc, instr); end
    endtask

    // Redirect coinciding with the ack for 300C
    task automatic test_redirect_ack();
        do_reset();
        repeat (3) @(negedge clk);
        lat = 1;
        #1;
        n_checks++; if (imem_addr !== 32'h300C || imem_ack !== 1'b0) begin n_fail++; $display("FAIL ra_issue: got %h/%b want 300C/0", imem_addr, imem_ack); end
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h5000;
        #1;
        n_checks++; if (imem_ack !== 1'b1 || imem_addr !== 32'h300C || valid !== 1'b0) begin n_fail++; $display("FAIL ra_ack: got %b/%h/%b want 1/300C/0", imem_ack, imem_addr, valid); end
        @(negedge clk);
        redirect = 1'b0;
        lat = 0;
        #1;
        n_checks++; if (valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h5000) begin n_fail++; $display("FAIL ra_next: got %b/%b/%h want 0/1/5000", valid, imem_req, imem_addr); end
        @(negedge clk); #1;
        n_checks++; if (valid !== 1'b1 || instr_pc !== 32'h5000 || instr !== 32'hFFFF5000) begin n_fail++; $display("FAIL ra_slot: got %b/%h/%h want 1/5000/FFFF5000", valid, instr_pc, instr); end
    endtask

    // Misaligned PC raises an address-error slot and halts fetch
    task automatic test_misaligned();
        do_reset();
        redirect = 1'b1;
        redirect_pc = 32'h3002;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL ma_redir_req: got %b want 0", imem_req); end
        @(negedge clk);
        redirect = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL ma_req0: got %b want 0", imem_req); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL ma_req%0d: got %b want 0", i + 1, imem_req); end
            n_checks++; if (valid !== 1'b1 || exc_adel !== 1'b1 || instr !== 32'h0 || instr_pc !== 32'h3002) begin n_fail++; $display("FAIL ma_slot%0d: got %b/%b/%h/%h want 1/1/0/3002", i, valid, exc_adel, instr, instr_pc); end
        end
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h3010;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL ma_redir2_req: got %b want 0", imem_req); end
        @(negedge clk);
        redirect = 1'b0;
        #1;
        n_checks++; if (valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3010) begin n_fail++; $display("FAIL ma_resume: got %b/%b/%h want 0/1/3010", valid, imem_req, imem_addr); end
        @(negedge clk); #1;
        n_checks++; if (valid !== 1'b1 || exc_adel !== 1'b0 || instr_pc !== 32'h3010 || instr !== 32'hFFFF3010) begin n_fail++; $display("FAIL ma_slot_ok: got %b/%b/%h/%h want 1/0/3010/FFFF3010", valid, exc_adel, instr_pc, instr); end
    endtask

    // PC increment wraps past 2^32
    task automatic test_wrap();
        do_reset();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_addr: got %b/%h want 1/FFFFFFFC", imem_req, imem_addr); end
        @(negedge clk); #1;
        n_checks++; if (imem_addr !== 32'h0 || instr_pc !== 32'hFFFF_FFFC || instr !== 32'h0000_FFFC) begin n_fail++; $display("FAIL wr_next: got %h/%h/%h want 0/FFFFFFFC/0000FFFC", imem_addr, instr_pc, instr); end
    endtask

    // Asynchronous reset asserted while waiting on 3004
    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        lat = 3;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004) begin n_fail++; $display("FAIL ar_issue: got %b/%h want 1/3004", imem_req, imem_addr); end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (valid !== 1'b0 || imem_addr !== 32'h3000) begin n_fail++; $display("FAIL ar_now: got %b/%h want 0/3000", valid, imem_addr); end
        @(negedge clk);
        reset = 1'b0;
        lat = 0;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin n_fail++; $display("FAIL ar_first: got %b/%h want 1/3000", imem_req, imem_addr); end
        @(negedge clk); #1;
        n_checks++; if (valid !== 1'b1 || instr_pc !== 32'h3000 || instr !== 32'hFFFF3000) begin n_fail++; $display("FAIL ar_slot: got %b/%h/%h want 1/3000/FFFF3000", valid, instr_pc, instr); end
    endtask

    initial begin
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        stall = 1'b0;
        test_reset();
        test_back_to_back_stall();
        test_redirect_wait();
        test_redirect_ack();
        test_misaligned();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
